sv32_table_walk: RTL and testbench

SV32_TABLE_WALK -- requirements
Module: sv32_table_walk

---
 rtl/sv32_table_walk.sv | 152 +++++++++++++++
 tb/tb_sv32_table_walk.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sv32_table_walk.sv
// ----------------------------------------------------------------------------
// sv32_table_walk
//   Sv32 hardware page-table walker. It accepts one translation request at a
//   time and reads at most two PTEs: level 1 first, then level 0 when the
//   level-1 entry points to another table. It returns a single normalised
//   leaf PTE. Any fault returns all-zero, so every later permission check
//   fails. A/D bits are only checked, never written back.
//
// Ports
//   clk, rst          : clock, synchronous active-high reset
//   walk_valid/ready  : request (held until ready) / one-cycle completion pulse
//   address, is_write : virtual address and store flag, stable while requested
//   satp              : root page-table PPN in satp[21:0]
//   pte_              : translated PTE, registered, valid with walk_ready
//   mem_valid/ready   : PTE read request (held until ready) / read complete
//   mem_addr          : 34-bit physical address of the PTE being read
//   mem_rdata         : PTE read data, valid with mem_ready
// ----------------------------------------------------------------------------
module sv32_table_walk (
    input  logic        clk,
    input  logic        rst,
    input  logic        walk_valid,
    output logic        walk_ready,
    input  logic [31:0] address,
    input  logic        is_write,
    input  logic [31:0] satp,
    output logic [31:0] pte_,
    output logic        mem_valid,
    input  logic        mem_ready,
    output logic [33:0] mem_addr,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [1:0] {
        IDLE,
        L1,
        L0,
        DONE
    } state_t;

    state_t      state_q, state_d;
    logic [9:0]  vpn0_q, vpn0_d;
    logic        is_write_q, is_write_d;
    logic        mem_valid_q, mem_valid_d;
    logic [33:0] mem_addr_q, mem_addr_d;
    logic [31:0] pte_q, pte_d;

    logic [33:0] root_base;
    logic        pte_invalid;
    logic        pte_is_table;
    logic        leaf_fault;
    logic        mega_misaligned;
    logic        unused_ok;

    // These address and satp bits are not used by the walk.
    assign unused_ok = ^{address[11:0], satp[31:22]};

    assign root_base = {satp[21:0], 12'h000};

    // PTE bits: V=0 R=1 W=2 X=3 U=4 G=5 A=6 D=7.
    assign pte_invalid     = !mem_rdata[0] || (!mem_rdata[1] && mem_rdata[2]);
    assign pte_is_table    = !mem_rdata[1] && !mem_rdata[3];
    assign leaf_fault      = !mem_rdata[6]
                           || (is_write_q && !mem_rdata[7])
                           || (mem_rdata[31:30] != 2'b00);
    assign mega_misaligned = (mem_rdata[19:10] != 10'd0);

    always_comb begin
        state_d     = state_q;
        vpn0_d      = vpn0_q;
        is_write_d  = is_write_q;
        mem_valid_d = mem_valid_q;
        mem_addr_d  = mem_addr_q;
        pte_d       = pte_q;

        case (state_q)
            IDLE: begin
                if (walk_valid) begin
                    state_d     = L1;
                    vpn0_d      = address[21:12];
                    is_write_d  = is_write;
                    mem_valid_d = 1'b1;
                    mem_addr_d  = root_base + {22'd0, address[31:22], 2'b00};
                end
            end
            L1: begin
                if (mem_ready) begin
                    if (pte_invalid) begin
                        state_d     = DONE;
                        mem_valid_d = 1'b0;
                        pte_d       = '0;
                    end else if (pte_is_table) begin
                        // mem_valid stays high: the level-0 read begins at
                        // once, keeping the two-level walk at 3 cycles.
                        state_d    = L0;
                        mem_addr_d = {mem_rdata[31:10], 12'h000}
                                   + {22'd0, vpn0_q, 2'b00};
                    end else begin
                        state_d     = DONE;
                        mem_valid_d = 1'b0;
                        if (leaf_fault || mega_misaligned) begin
                            pte_d = '0;
                        end else begin
                            pte_d = {mem_rdata[29:20], vpn0_q, 2'b00, mem_rdata[9:0]};
                        end
                    end
                end
            end
            L0: begin
                if (mem_ready) begin
                    state_d     = DONE;
                    mem_valid_d = 1'b0;
                    if (pte_invalid || pte_is_table || leaf_fault) begin
                        pte_d = '0;
                    end else begin
                        pte_d = {mem_rdata[29:10], 2'b00, mem_rdata[9:0]};
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            vpn0_q      <= '0;
            is_write_q  <= 1'b0;
            mem_valid_q <= 1'b0;
            mem_addr_q  <= '0;
            pte_q       <= '0;
        end else begin
            state_q     <= state_d;
            vpn0_q      <= vpn0_d;
            is_write_q  <= is_write_d;
            mem_valid_q <= mem_valid_d;
            mem_addr_q  <= mem_addr_d;
            pte_q       <= pte_d;
        end
    end

    assign walk_ready = (state_q == DONE);
    assign mem_valid  = mem_valid_q;
    assign mem_addr   = mem_addr_q;
    assign pte_       = pte_q;

endmodule

// File: tb/tb_sv32_table_walk.sv
// ----------------------------------------------------------------------------
// tb_sv32_table_walk
//   Directed-vector bench for sv32_table_walk. Each walk queues its expected
//   PTE-read addresses and the expected output PTE. A memory responder serves
//   reads from a data queue and can add a programmable number of wait cycles.
//   A monitor then checks every read handshake and every walk_ready pulse
//   against those queues.
// ----------------------------------------------------------------------------
module tb_sv32_table_walk;

    logic        clk;
    logic        rst;
    logic        walk_valid;
    logic        walk_ready;
    logic [31:0] address;
    logic        is_write;
    logic [31:0] satp;
    logic [31:0] pte_;
    logic        mem_valid;
    logic        mem_ready;
    logic [33:0] mem_addr;
    logic [31:0] mem_rdata;

    sv32_table_walk dut (
        .clk        (clk),
        .rst        (rst),
        .walk_valid (walk_valid),
        .walk_ready (walk_ready),
        .address    (address),
        .is_write   (is_write),
        .satp       (satp),
        .pte_       (pte_),
        .mem_valid  (mem_valid),
        .mem_ready  (mem_ready),
        .mem_addr   (mem_addr),
        .mem_rdata  (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned checks = 0;
    int unsigned passes = 0;

    logic [33:0] exp_addr_q [$];
    logic [31:0] exp_pte_q  [$];
    logic [31:0] rdata_q    [$];

    bit          mem_auto = 1'b1;
    int unsigned mem_wait = 0;

    task automatic check(input string name, input logic [33:0] act, input logic [33:0] exp);
        checks++;
        if (act === exp) begin
            passes++;
        end else begin
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    // Memory responder: drives mem_ready/mem_rdata just after each rising edge.
    initial begin
        int unsigned wait_cnt;
        wait_cnt = 0;
        forever begin
            @(posedge clk);
            #1;
            if (mem_auto) begin
                if (mem_valid) begin
                    if (wait_cnt >= mem_wait) begin
                        mem_ready = 1'b1;
                        mem_rdata = (rdata_q.size() > 0) ? rdata_q.pop_front() : 32'h0;
                        wait_cnt  = 0;
                    end else begin
                        mem_ready = 1'b0;
                        wait_cnt++;
                    end
                end else begin
                    mem_ready = 1'b0;
                    wait_cnt  = 0;
                end
            end
        end
    end

    // Monitor: compares DUT outputs against the scoreboard at each falling edge.
    initial begin
        logic        prev_valid;
        logic        prev_hs;
        logic [33:0] prev_addr;
        prev_valid = 1'b0;
        prev_hs    = 1'b0;
        prev_addr  = '0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (mem_valid && prev_valid && !prev_hs) begin
                    check("mem_addr_stable", mem_addr, prev_addr);
                end
                if (mem_valid && mem_ready) begin
                    if (exp_addr_q.size() == 0) begin
                        checks++;
                        $display("FAIL unexpected_mem_read: got addr %h, required no read", mem_addr);
                    end else begin
                        check("mem_addr", mem_addr, exp_addr_q.pop_front());
                    end
                end
                if (walk_ready) begin
                    if (exp_pte_q.size() == 0) begin
                        checks++;
                        $display("FAIL unexpected_walk_ready: got pte_ %h, required no pulse", pte_);
                    end else begin
                        check("pte_", {2'b00, pte_}, {2'b00, exp_pte_q.pop_front()});
                    end
                end
            end
            prev_valid = mem_valid;
            prev_hs    = mem_valid && mem_ready;
            prev_addr  = mem_addr;
        end
    end

    // Issue one walk; returns at the falling edge where walk_ready is seen.
    task automatic do_walk(input logic [31:0] s, input logic [31:0] va, input logic wr,
                           input int unsigned nrd,
                           input logic [31:0] rd1, input logic [33:0] a1,
                           input logic [31:0] rd0, input logic [33:0] a0,
                           input logic [31:0] exp_pte, input int unsigned lat,
                           input int unsigned wt, input bit rel_rst);
        int unsigned n;
        rdata_q.push_back(rd1);
        exp_addr_q.push_back(a1);
        if (nrd == 2) begin
            rdata_q.push_back(rd0);
            exp_addr_q.push_back(a0);
        end
        exp_pte_q.push_back(exp_pte);
        mem_wait = wt;
        @(posedge clk);
        #1;
        satp       = s;
        address    = va;
        is_write   = wr;
        walk_valid = 1'b1;
        if (rel_rst) rst = 1'b0;
        n = 0;
        forever begin
            @(negedge clk);
            if (walk_ready) break;
            n++;
            if (n > 200) break;
        end
        if (n > 200) begin
            checks++;
            $display("FAIL walk_timeout: got no walk_ready in 200 cycles, required %0d", lat);
        end else begin
            check("latency", 34'(n), 34'(lat));
            check("mem_valid_at_ready", {33'd0, mem_valid}, 34'd0);
        end
    endtask

    task automatic idle(input int unsigned cycles);
        @(posedge clk);
        #1;
        walk_valid = 1'b0;
        is_write   = 1'b0;
        repeat (cycles) @(posedge clk);
    endtask

    localparam logic [31:0] SATP = 32'h8000_0080;
    localparam logic [31:0] VA   = 32'h0040_1234;

    initial begin
        rst        = 1'b1;
        walk_valid = 1'b0;
        address    = '0;
        is_write   = 1'b0;
        satp       = '0;
        mem_ready  = 1'b0;
        mem_rdata  = '0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_walk_ready", {33'd0, walk_ready}, 34'd0);
        check("rst_mem_valid",  {33'd0, mem_valid},  34'd0);
        check("rst_mem_addr",   mem_addr,            34'd0);
        check("rst_pte",        {2'b00, pte_},       34'd0);

        // Two-level walk, requested in the first cycle out of reset.
        do_walk(SATP, VA, 1'b0, 2, 32'h0002_4001, 34'h8_0004, 32'h0003_00CF, 34'h9_0004,
                32'h000C_00CF, 3, 0, 1'b1);
        idle(2);
        // Megapage.
        do_walk(SATP, VA, 1'b0, 1, 32'h2000_00CF, 34'h8_0004, 32'h0, 34'h0,
                32'h8000_10CF, 2, 0, 1'b0);
        idle(1);
        // Level-1 invalid.
        do_walk(SATP, VA, 1'b0, 1, 32'h0000_0000, 34'h8_0004, 32'h0, 34'h0,
                32'h0, 2, 0, 1'b0);
        idle(1);
        // Misaligned megapage.
        do_walk(SATP, VA, 1'b0, 1, 32'h2000_04CF, 34'h8_0004, 32'h0, 34'h0,
                32'h0, 2, 0, 1'b0);
        idle(1);
        // Level-1 W without R.
        do_walk(SATP, VA, 1'b0, 1, 32'h0000_0005, 34'h8_0004, 32'h0, 34'h0,
                32'h0, 2, 0, 1'b0);
        idle(1);
        // Megapage with PTE[31:30] nonzero.
        do_walk(SATP, VA, 1'b0, 1, 32'h4000_00CF, 34'h8_0004, 32'h0, 34'h0,
                32'h0, 2, 0, 1'b0);
        idle(1);
        // Store to a leaf with D=0.
        do_walk(SATP, VA, 1'b1, 2, 32'h0002_4001, 34'h8_0004, 32'h0003_004F, 34'h9_0004,
                32'h0, 3, 0, 1'b0);
        idle(1);
        // Store to a leaf with D=1.
        do_walk(SATP, VA, 1'b1, 2, 32'h0002_4001, 34'h8_0004, 32'h0003_00CF, 34'h9_0004,
                32'h000C_00CF, 3, 0, 1'b0);
        idle(1);
        // Level-0 entry that is itself a pointer.
        do_walk(SATP, VA, 1'b0, 2, 32'h0002_4001, 34'h8_0004, 32'h0000_0001, 34'h9_0004,
                32'h0, 3, 0, 1'b0);
        idle(1);
        // Level-0 leaf with A=0.
        do_walk(SATP, VA, 1'b0, 2, 32'h0002_4001, 34'h8_0004, 32'h0003_008F, 34'h9_0004,
                32'h0, 3, 0, 1'b0);
        idle(1);
        // Five wait cycles per level.
        do_walk(SATP, VA, 1'b0, 2, 32'h0002_4001, 34'h8_0004, 32'h0003_00CF, 34'h9_0004,
                32'h000C_00CF, 13, 5, 1'b0);
        idle(1);
        // Top-of-range address arithmetic.
        do_walk(32'h003F_FFFF, 32'hFFC0_0000, 1'b0, 1, 32'h0000_0000, 34'h3_FFFF_FFFC,
                32'h0, 34'h0, 32'h0, 2, 0, 1'b0);
        // Back-to-back: a megapage, then a two-level walk in the next cycle.
        do_walk(SATP, VA, 1'b0, 1, 32'h2000_00CF, 34'h8_0004, 32'h0, 34'h0,
                32'h8000_10CF, 2, 0, 1'b0);
        do_walk(SATP, VA, 1'b0, 2, 32'h0002_4001, 34'h8_0004, 32'h0003_00CF, 34'h9_0004,
                32'h000C_00CF, 3, 0, 1'b0);
        idle(1);

        // Reset during L0, followed one cycle later by a late mem_ready.
        mem_auto = 1'b0;
        exp_addr_q.push_back(34'h8_0004);
        @(posedge clk);
        #1;
        satp       = SATP;
        address    = VA;
        walk_valid = 1'b1;
        @(posedge clk);
        #1;
        mem_ready  = 1'b1;
        mem_rdata  = 32'h0002_4001;
        @(posedge clk);
        #1;
        mem_ready  = 1'b0;
        walk_valid = 1'b0;
        rst        = 1'b1;
        @(posedge clk);
        #1;
        rst        = 1'b0;
        mem_ready  = 1'b1;
        mem_rdata  = 32'h0003_00CF;
        @(negedge clk);
        check("abort_mem_valid", {33'd0, mem_valid}, 34'd0);
        check("abort_mem_addr",  mem_addr,           34'd0);
        @(posedge clk);
        #1;
        mem_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("abort_walk_ready", {33'd0, walk_ready}, 34'd0);
        end
        mem_auto = 1'b1;
        do_walk(SATP, VA, 1'b0, 2, 32'h0002_4001, 34'h8_0004, 32'h0003_00CF, 34'h9_0004,
                32'h000C_00CF, 3, 0, 1'b0);
        idle(3);

        check("pending_addr_reads", 34'(exp_addr_q.size()), 34'd0);
        check("pending_walks",      34'(exp_pte_q.size()),  34'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
